arithmetic_unit: RTL and testbench

// - Registered 4-bit arithmetic unit: add, subtract, increment and decrement on
//   two unsigned/two's-complement operands, plus status flags.
// - Arithmetic half of the ALU. A logic unit sits beside it, and a result mux

---
 rtl/arithmetic_unit_if.sv | 55 +++++
 rtl/arithmetic_unit.sv | 129 ++++++++++++
 tb/tb_arithmetic_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/arithmetic_unit_if.sv
// Operand/result bundle for the arithmetic unit.
//
// master : drives in_valid, A, B, S; observes result and flags.
// slave  : the arithmetic unit; consumes operands, drives result and flags.
//
// Signals:
//   in_valid  operands and S are valid this cycle
//   A, B      operands (B ignored for increment/decrement)
//   S         operation select: 00 add, 01 sub, 10 inc, 11 dec
//   result    registered result
//   carry     carry out (add/inc) or borrow (sub/dec)
//   overflow  signed two's-complement overflow
//   zero      result == 0
//   negative  result MSB
//   out_valid outputs hold a fresh result this cycle
interface arithmetic_unit_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       S;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             out_valid;

    modport master (
        output in_valid,
        output A,
        output B,
        output S,
        input  result,
        input  carry,
        input  overflow,
        input  zero,
        input  negative,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  S,
        output result,
        output carry,
        output overflow,
        output zero,
        output negative,
        output out_valid
    );
endinterface

// File: rtl/arithmetic_unit.sv
// Registered arithmetic unit: add, subtract, increment and decrement with
// carry/borrow, signed overflow, zero and negative flags. One cycle latency,
// no backpressure; every output comes straight from a flop.
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset; clears all outputs, wins over in_valid
//   bus  arithmetic_unit_if slave modport (operands in, result/flags out)
module arithmetic_unit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    arithmetic_unit_if.slave  bus
);

    // Second operand after operation decode; inc/dec substitute the constant 1.
    logic [WIDTH-1:0] opb;
    logic             subtract;

    // One extra bit so the carry/borrow falls out of the arithmetic directly.
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             overflow_d;
    logic             zero_d;
    logic             negative_d;

    logic             a_msb;
    logic             b_msb;
    logic             r_msb;

    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             overflow_q;
    logic             zero_q;
    logic             negative_q;
    logic             valid_q;

    // Plain case: S may be X while in_valid is low, which must not trip
    // uniqueness checks.
    always_comb begin
        opb      = bus.B;
        subtract = 1'b0;
        case (bus.S)
            2'b00: begin
                opb      = bus.B;
                subtract = 1'b0;
            end
            2'b01: begin
                opb      = bus.B;
                subtract = 1'b1;
            end
            2'b10: begin
                opb      = WIDTH'(1);
                subtract = 1'b0;
            end
            2'b11: begin
                opb      = WIDTH'(1);
                subtract = 1'b1;
            end
            default: begin
                opb      = bus.B;
                subtract = 1'b0;
            end
        endcase
    end

    // For subtraction the top bit of the zero-extended difference is set
    // exactly when A < opb unsigned, i.e. the borrow.
    always_comb begin
        if (subtract) begin
            ext = {1'b0, bus.A} - {1'b0, opb};
        end else begin
            ext = {1'b0, bus.A} + {1'b0, opb};
        end
    end

    assign res_d   = ext[WIDTH-1:0];
    assign carry_d = ext[WIDTH];

    assign a_msb = bus.A[WIDTH-1];
    assign b_msb = opb[WIDTH-1];
    assign r_msb = res_d[WIDTH-1];

    // Signed overflow: the result sign disagrees with A when the effective
    // operands (B negated for subtraction) share A's sign.
    always_comb begin
        overflow_d = 1'b0;
        if (subtract) begin
            overflow_d = (a_msb != b_msb) && (r_msb != a_msb);
        end else begin
            overflow_d = (a_msb == b_msb) && (r_msb != a_msb);
        end
    end

    assign zero_d     = (res_d == '0);
    assign negative_d = r_msb;

    // Result and flags load only on in_valid, so X operands while idle never
    // reach the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                result_q   <= res_d;
                carry_q    <= carry_d;
                overflow_q <= overflow_d;
                zero_q     <= zero_d;
                negative_q <= negative_d;
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = negative_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_arithmetic_unit.sv
// Self-checking bench for arithmetic_unit (WIDTH=4) using a scoreboard queue.
module tb_arithmetic_unit;

    localparam int unsigned WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             o;
        logic             z;
        logic             n;
    } exp_t;

    logic clk;
    logic rst;

    arithmetic_unit_if #(.WIDTH(WIDTH)) bus ();

    arithmetic_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t held;
    logic exp_ov  = 1'b0;
    logic mon_en  = 1'b0;
    int   pulses  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model in plain integer arithmetic.
    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        exp_t e;
        int ia, ib, full, sa, sb_i, sf;
        logic [1:0] sel;
        sel  = s;
        ia   = int'(a);
        ib   = sel[1] ? 1 : int'(b);
        full = sel[0] ? (ia - ib) : (ia + ib);
        e.res = full[3:0];
        e.c   = sel[0] ? (ia < ib) : (full > 15);
        sa    = (ia >= 8) ? ia - 16 : ia;
        sb_i  = (ib >= 8) ? ib - 16 : ib;
        sf    = sel[0] ? (sa - sb_i) : (sa + sb_i);
        e.o   = (sf > 7) || (sf < -8);
        e.z   = (e.res == 4'd0);
        e.n   = e.res[3];
        return e;
    endfunction

    // Drive one cycle: inputs are sampled at the next rising edge.
    task automatic apply(input logic r, input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic [1:0] s);
        exp_t e;
        rst          = r;
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        bus.S        = s;
        e = model(a, b, s);
        @(posedge clk);
        if (r) begin
            sb.delete();
            held   = '0;
            exp_ov = 1'b0;
        end else begin
            exp_ov = v;
            if (v) sb.push_back(e);
        end
        mon_en = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
            if (exp_ov) begin
                check("sb_depth", 32'(sb.size()), 32'd1);
                if (sb.size() > 0) held = sb.pop_front();
            end
            check("result",   32'(bus.result),   32'(held.res));
            check("carry",    32'(bus.carry),    32'(held.c));
            check("overflow", 32'(bus.overflow), 32'(held.o));
            check("zero",     32'(bus.zero),     32'(held.z));
            check("negative", 32'(bus.negative), 32'(held.n));
            if (bus.out_valid) pulses++;
        end
    end

    initial begin
        held = '0;
        rst  = 1'b1;
        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.S = '0;

        // Reset with in_valid high: reset wins.
        apply(1'b1, 1'b1, 4'b0111, 4'b0100, 2'b00);
        apply(1'b1, 1'b1, 4'b0111, 4'b0100, 2'b00);

        // Directed cases.
        apply(1'b0, 1'b1, 4'b0111, 4'b0100, 2'b00);
        apply(1'b0, 1'b1, 4'b0111, 4'b0110, 2'b01);
        apply(1'b0, 1'b1, 4'b0000, 4'b0001, 2'b01);
        apply(1'b0, 1'b1, 4'b0110, 4'b0111, 2'b11);
        apply(1'b0, 1'b1, 4'b1000, 4'bxxxx, 2'b11);
        apply(1'b0, 1'b1, 4'b1111, 4'bxxxx, 2'b10);

        // Idle with X operands: outputs hold.
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 4'bxxxx, 4'bxxxx, 2'bxx);

        // Random mix of valid and idle cycles.
        for (int i = 0; i < 40; i++) begin
            apply(1'b0, ($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                  2'($urandom));
        end
        apply(1'b0, 1'b1, 4'b1000, 4'b0001, 2'b01);
        apply(1'b0, 1'b1, 4'b0000, 4'b0000, 2'b11);
        apply(1'b0, 1'b1, 4'b1000, 4'b1000, 2'b00);

        // Three back-to-back ops give three pulses.
        apply(1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
        pulses = 0;
        apply(1'b0, 1'b1, 4'd3, 4'd4, 2'b00);
        apply(1'b0, 1'b1, 4'd9, 4'd2, 2'b01);
        apply(1'b0, 1'b1, 4'd5, 4'd0, 2'b10);
        apply(1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
        apply(1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
        check("stream_pulses", 32'(pulses), 32'd3);

        // Reset during the second op of a stream discards it.
        apply(1'b0, 1'b1, 4'd6, 4'd6, 2'b00);
        apply(1'b1, 1'b1, 4'd5, 4'd5, 2'b01);
        apply(1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
        apply(1'b0, 1'b1, 4'd2, 4'd7, 2'b01);
        apply(1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
        apply(1'b0, 1'b0, 4'd0, 4'd0, 2'b00);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
